// File: rtl/unidade_controle_jogo.sv
// -----------------------------------------------------------------------------
// unidade_controle_jogo
//
// Moore control unit for the memory game. It clears the datapath, plays back
// the ROM sequence (one item per display-timer period), collects the player's
// moves under the move timeout, and grows the round by one after every correct
// round. It reports a win, a mistake or a timeout.
//
// Ports:
//   clock                   system clock (1000 Hz)
//   reset                   synchronous reset, active low
//   iniciar                 start / restart request (level)
//   jogada_feita            one-cycle move pulse from the edge detector
//   igual                   registered move matches the ROM data
//   enderecoIgualSequencia  address counter equals sequence counter
//   fimS                    sequence counter RCO (end of game when USA_FIMS=1)
//   fimTMR                  display timer end
//   timeout                 move timeout flag
//   db_sequencia_in         sequence count (end of game when USA_FIMS=0)
//   zera*, registra*, conta* datapath controls
//   pronto, ganhou, perdeu, db_timeout  game status
//   db_estado               current state code
//
// Outputs are registered together with the state: each cycle the decode of
// the next state is captured, so outputs always match db_estado and never
// depend combinationally on the inputs.
// -----------------------------------------------------------------------------
module unidade_controle_jogo #(
   parameter logic [3:0] ULTIMA_RODADA = 4'd15,
   parameter bit         USA_FIMS      = 1'b1
) (
   input  logic       clock,
   input  logic       reset,
   input  logic       iniciar,
   input  logic       jogada_feita,
   input  logic       igual,
   input  logic       enderecoIgualSequencia,
   input  logic       fimS,
   input  logic       fimTMR,
   input  logic       timeout,
   input  logic [3:0] db_sequencia_in,
   output logic       zeraR,
   output logic       zeraE,
   output logic       zeraS,
   output logic       zeraM,
   output logic       zeraTMR,
   output logic       registraR,
   output logic       registraM,
   output logic       contaE,
   output logic       contaS,
   output logic       contaTMR,
   output logic       pronto,
   output logic       ganhou,
   output logic       perdeu,
   output logic       db_timeout,
   output logic [3:0] db_estado
);

   typedef enum logic [3:0] {
      Inicial       = 4'h0,
      Preparacao    = 4'h1,
      IniciaRodada  = 4'h2,
      Mostra        = 4'h3,
      ProximoMostra = 4'h4,
      FimMostra     = 4'h5,
      Espera        = 4'h6,
      Registra      = 4'h7,
      Compara       = 4'h8,
      Ultima        = 4'h9,
      ProximaRodada = 4'hA,
      ProximaJogada = 4'hB,
      Esgotado      = 4'hC,
      Acertou       = 4'hD,
      Errou         = 4'hE,
      Invalido      = 4'hF
   } estado_t;

   // Output vector bit order:
   // {zeraR, zeraE, zeraS, zeraM, zeraTMR, registraR, registraM,
   //  contaE, contaS, contaTMR, pronto, ganhou, perdeu, db_timeout}
   estado_t     estado_q, estado_d;
   logic [13:0] saidas_q, saidas_d;
   logic        fim_jogo;

   assign fim_jogo = USA_FIMS ? fimS : (db_sequencia_in == ULTIMA_RODADA);

   always_comb begin
      estado_d = estado_q;
      case (estado_q)
         Inicial:       if (iniciar) estado_d = Preparacao;
         Preparacao:    estado_d = IniciaRodada;
         IniciaRodada:  estado_d = Mostra;
         // ROM data for the new address is only valid a cycle after contaE,
         // so the last-item test is made here rather than in ProximoMostra.
         Mostra:        if (fimTMR) estado_d = enderecoIgualSequencia ? FimMostra : ProximoMostra;
         ProximoMostra: estado_d = Mostra;
         FimMostra:     estado_d = Espera;
         Espera: begin
            // A move in the same cycle as the timeout wins.
            if (jogada_feita)  estado_d = Registra;
            else if (timeout)  estado_d = Esgotado;
         end
         Registra:      estado_d = Compara;
         Compara: begin
            if (!igual)                      estado_d = Errou;
            else if (enderecoIgualSequencia) estado_d = Ultima;
            else                             estado_d = ProximaJogada;
         end
         Ultima:        estado_d = fim_jogo ? Acertou : ProximaRodada;
         ProximaRodada: estado_d = IniciaRodada;
         ProximaJogada: estado_d = Espera;
         Esgotado, Acertou, Errou: if (iniciar) estado_d = Preparacao;
         default:       estado_d = Inicial;
      endcase
   end

   always_comb begin
      saidas_d = '0;
      case (estado_d)
         Preparacao:    saidas_d = 14'b11111_00000_0000;
         IniciaRodada:  saidas_d = 14'b11001_00000_0000;
         Mostra:        saidas_d = 14'b00000_01001_0000;
         ProximoMostra: saidas_d = 14'b00001_00100_0000;
         FimMostra:     saidas_d = 14'b01011_00000_0000;
         Registra:      saidas_d = 14'b00000_10000_0000;
         ProximaRodada: saidas_d = 14'b10000_00010_0000;
         ProximaJogada: saidas_d = 14'b10000_00100_0000;
         Esgotado:      saidas_d = 14'b00000_00000_1011;
         Acertou:       saidas_d = 14'b00000_00000_1100;
         Errou:         saidas_d = 14'b00000_00000_1010;
         default:       saidas_d = '0;
      endcase
   end

   always_ff @(posedge clock) begin
      if (!reset) begin
         estado_q <= Inicial;
         saidas_q <= '0;
      end else begin
         estado_q <= estado_d;
         saidas_q <= saidas_d;
      end
   end

   assign {zeraR, zeraE, zeraS, zeraM, zeraTMR, registraR, registraM,
           contaE, contaS, contaTMR, pronto, ganhou, perdeu, db_timeout} = saidas_q;
   assign db_estado = estado_q;

endmodule
